multi_edge_pulse_fsm: RTL

- Parametrised multi-channel successor to the single-channel level-to-pulse one-shot.
- Each channel detects a selectable edge (rise, fall or both) on a synchronous level input.
- On a detected edge it emits a registered, glitch-free pulse of configurable length, followed by a configurable re-trigger holdoff.
- Used between debounced switch/button synchronisers and the command/strobe logic of the ACL tester.

---
 rtl/multi_edge_pulse_fsm.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multi_edge_pulse_fsm.sv
// multi_edge_pulse_fsm
// Multi-channel edge-to-pulse one-shot. Each channel watches a synchronous
// level input for a selectable edge and answers with a registered pulse of
// PULSE_LEN cycles, followed by HOLDOFF cycles during which new edges are
// ignored.
//
// Optional feature: define MULTI_EDGE_PULSE_MISSED_EN to build the sticky
// missed-edge flags. Without it, o_missed is tied to 0 and i_clear is ignored.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   i_level   per-channel level inputs, already synchronous to clk
//   i_mode    per-channel edge mode, bits [2c+1:2c]:
//             00 rise, 01 fall, 10 both, 11 disabled
//   i_clear   clears all o_missed bits
//   o_pulse   registered one-shot pulses
//   o_busy    registered, high while the channel is pulsing or in holdoff
//   o_missed  sticky flags: an edge arrived while the channel was busy
//
// Channel FSM:
//   state    | meaning
//   ST_IDLE  | waiting for a qualifying edge
//   ST_PULSE | driving the pulse, cnt counts down the remaining cycles
//   ST_HOLD  | holdoff after the pulse, edges are dropped
module multi_edge_pulse_fsm #(
    parameter int NUM_CH    = 4,
    parameter int PULSE_LEN = 1,
    parameter int HOLDOFF   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     i_level,
    input  logic [2*NUM_CH-1:0]   i_mode,
    input  logic                  i_clear,
    output logic [NUM_CH-1:0]     o_pulse,
    output logic [NUM_CH-1:0]     o_busy,
    output logic [NUM_CH-1:0]     o_missed
);

    localparam int CNT_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PULSE = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] pulse_vec;
    logic [NUM_CH-1:0] busy_vec;
    logic [NUM_CH-1:0] miss_set;

    // Tracking i_level during reset as well means a level already high when
    // reset releases is not seen as a rising edge.
    always_ff @(posedge clk) begin
        prev <= i_level;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]    state;
        logic [1:0]    state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          rise;
        logic          fall;
        logic          qual;

        assign rise = i_level[c] & ~prev[c];
        assign fall = ~i_level[c] & prev[c];

        always_comb begin
            qual = 1'b0;
            case (i_mode[2*c +: 2])
                2'b00:   qual = rise;
                2'b01:   qual = fall;
                2'b10:   qual = rise | fall;
                default: qual = 1'b0;
            endcase
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_IDLE: begin
                    if (qual) begin
                        state_nxt = ST_PULSE;
                        cnt_nxt   = PULSE_LOAD;
                    end
                end
                ST_PULSE: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else if (HOLDOFF > 0) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        assign pulse_vec[c] = (state == ST_PULSE);
        assign busy_vec[c]  = (state == ST_PULSE) || (state == ST_HOLD);
        assign miss_set[c]  = qual & busy_vec[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pulse <= '0;
            o_busy  <= '0;
        end else begin
            o_pulse <= pulse_vec;
            o_busy  <= busy_vec;
        end
    end

`ifdef MULTI_EDGE_PULSE_MISSED_EN
    logic [NUM_CH-1:0] missed_q;

    // A new miss in the same cycle as i_clear stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            missed_q <= '0;
        end else begin
            missed_q <= miss_set | (i_clear ? '0 : missed_q);
        end
    end

    assign o_missed = missed_q;
`else
    logic unused_ok;
    assign unused_ok = ^{i_clear, miss_set};
    assign o_missed  = '0;
`endif

endmodule
